// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one word access at a time over req/ready/ack,
// fixed LATENCY cycles from acceptance to ack, per-byte store enables, error on bad address.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          commit;
    logic          addr_err;
    logic [AW-1:0] idx;

    assign idx      = addr_q[AW+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
    assign accept   = req_i & ready_o;
    assign commit   = (state_q == WAIT) && (cnt_q == 4'd0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        ack_o   = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (req_i) state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = DONE;
            end
            DONE: begin
                ack_o   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, latency counter and completion status
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                be_q    <= be_i;
                cnt_q   <= 4'(LATENCY - 1);
            end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (commit) begin
                err_q <= addr_err;
                if (addr_err)   rdata_q <= 32'd0;
                else if (!we_q) rdata_q <= mem[idx];
            end else if (state_q == DONE) begin
                err_q <= 1'b0;
            end
        end
    end

    // Storage array is deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (commit && we_q && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;
    assign err_o   = err_q;
    assign stall_o = req_i & ~ack_o;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, handshake/abort sequences and
// randomized accesses against a word-array reference model.
module tb_dmem_responder;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, b_rst_n;
    logic        req, we, cur;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        a_req, b_req;
    logic        a_ready, a_ack, a_err, a_stall;
    logic        b_ready, b_ack, b_err, b_stall;
    logic [31:0] a_rdata, b_rdata;
    logic        o_ready, o_ack, o_err, o_stall;
    logic [31:0] o_rdata;

    assign a_req   = req & ~cur;
    assign b_req   = req & cur;
    assign o_ready = cur ? b_ready : a_ready;
    assign o_ack   = cur ? b_ack   : a_ack;
    assign o_err   = cur ? b_err   : a_err;
    assign o_stall = cur ? b_stall : a_stall;
    assign o_rdata = cur ? b_rdata : a_rdata;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) dut_a (
        .clk_i(clk), .rst_n_i(a_rst_n), .req_i(a_req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .ready_o(a_ready), .ack_o(a_ack),
        .rdata_o(a_rdata), .err_o(a_err), .stall_o(a_stall));

    dmem_responder #(.DEPTH(256), .LATENCY(4)) dut_b (
        .clk_i(clk), .rst_n_i(b_rst_n), .req_i(b_req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .ready_o(b_ready), .ack_o(b_ack),
        .rdata_o(b_rdata), .err_o(b_err), .stall_o(b_stall));

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: plain word array, byte lanes merged arithmetically
    logic [31:0] mdl_mem [256];
    logic [31:0] mdl_rdata = 32'd0;

    task automatic mdl_apply(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, output logic [31:0] exp_rd,
                             output logic exp_er);
        logic [31:0] word, mask;
        exp_er = (a % 4 != 0) || (a >= 32'd1024);
        if (exp_er) begin
            mdl_rdata = 32'd0;
        end else if (!w) begin
            mdl_rdata = mdl_mem[a / 4];
        end else begin
            mask = 32'd0;
            for (int i = 0; i < 4; i++) if (b[i]) mask = mask | (32'hFF << (8 * i));
            word = mdl_mem[a / 4];
            mdl_mem[a / 4] = (word & ~mask) | (d & mask);
        end
        exp_rd = mdl_rdata;
    endtask

    // Waits for ack from the current point; c0 negedges already elapsed since request
    task automatic wait_ack(input string nm, input int c0, input logic [31:0] exp_rd,
                            input logic exp_er);
        int  c;
        int  lat;
        logic got;
        lat = cur ? 4 : 2;
        c   = c0;
        got = 1'b0;
        while (!got && c < 40) begin
            @(negedge clk);
            c++;
            if (o_ack) got = 1'b1;
            else check({nm, "/stall_wait"}, 32'(o_stall), 32'd1);
        end
        if (!got) begin
            check({nm, "/ack_timeout"}, 32'(got), 32'd1);
        end else begin
            check({nm, "/latency"}, 32'(c), 32'(lat + 1));
            check({nm, "/rdata"}, o_rdata, exp_rd);
            check({nm, "/err"}, 32'(o_err), 32'(exp_er));
            check({nm, "/stall_ack"}, 32'(o_stall), 32'd0);
            check({nm, "/ready_ack"}, 32'(o_ready), 32'd0);
        end
        req = 1'b0;
    endtask

    task automatic access(input string nm, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          input logic [31:0] exp_rd, input logic exp_er);
        @(negedge clk);
        check({nm, "/idle_ack_err"}, {30'd0, o_ack, o_err}, 32'd0);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        #1;
        check({nm, "/stall_req"}, 32'(o_stall), 32'd1);
        check({nm, "/ready_req"}, 32'(o_ready), 32'd1);
        wait_ack(nm, 0, exp_rd, exp_er);
    endtask

    task automatic acc_model(input string nm, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] b);
        logic [31:0] er_d;
        logic        er_e;
        mdl_apply(w, a, d, b, er_d, er_e);
        access(nm, w, a, d, b, er_d, er_e);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dr;
        logic        de;
        int          acks, pos1, pos2;
        logic [31:0] ra;
        logic [3:0]  rk;

        tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h10,  32'h000000AA, 4'h1, 32'hDEADBEEF, 1'b0};
        tbl[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        tbl[4]  = '{1'b1, 32'h0,   32'h11223344, 4'hF, 32'hDEADBEAA, 1'b0};
        tbl[5]  = '{1'b0, 32'h13,  32'h0,        4'h0, 32'h00000000, 1'b1};
        tbl[6]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h11223344, 1'b0};
        tbl[8]  = '{1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h11223344, 1'b0};
        tbl[9]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        tbl[10] = '{1'b1, 32'h3FC, 32'h55AA55AA, 4'hF, 32'hDEADBEAA, 1'b0};
        tbl[11] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'h55AA55AA, 1'b0};
        tbl[12] = '{1'b1, 32'h12,  32'h0,        4'hF, 32'h00000000, 1'b1};
        tbl[13] = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        tbl[14] = '{1'b1, 32'h10,  32'h55667788, 4'hA, 32'hDEADBEAA, 1'b0};
        tbl[15] = '{1'b0, 32'h10,  32'h0,        4'h0, 32'h55AD77AA, 1'b0};

        cur = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(negedge clk);
        check("reset/ready", 32'(o_ready), 32'd1);
        check("reset/ack",   32'(o_ack),   32'd0);
        check("reset/rdata", o_rdata,      32'd0);
        check("reset/err",   32'(o_err),   32'd0);
        check("reset/stall", 32'(o_stall), 32'd0);

        for (int i = 0; i < 16; i++) begin
            mdl_apply(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, dr, de);
            access($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata,
                   tbl[i].be, tbl[i].exp_rd, tbl[i].exp_er);
        end

        // Inputs changed while WAIT must not affect the latched load
        mdl_apply(1'b0, 32'h10, 32'h0, 4'h0, dr, de);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h10; wdata = 32'h0; be = 4'h0;
        @(negedge clk);
        addr = 32'h0; we = 1'b1; wdata = 32'hFFFFFFFF; be = 4'hF;
        wait_ack("chg_load", 1, dr, de);
        acc_model("chg_load_chk", 1'b0, 32'h0, 32'h0, 4'h0);

        // Same for a store: late wdata/addr changes are ignored
        mdl_apply(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, dr, de);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D; be = 4'hF;
        @(negedge clk);
        addr = 32'h24; wdata = 32'h0; be = 4'h1;
        wait_ack("chg_store", 1, dr, de);
        acc_model("chg_store_chk", 1'b0, 32'h20, 32'h0, 4'h0);

        // req held through DONE: acks spaced LATENCY+2 apart
        mdl_apply(1'b0, 32'h0, 32'h0, 4'h0, dr, de);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'h0;
        acks = 0; pos1 = -1; pos2 = -1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (o_ack) begin
                acks++;
                if (pos1 < 0) pos1 = c; else pos2 = c;
                check($sformatf("hold/rdata@%0d", c), o_rdata, dr);
            end
        end
        req = 1'b0;
        check("hold/acks", 32'(acks), 32'd2);
        check("hold/pos1", 32'(pos1), 32'd3);
        check("hold/pos2", 32'(pos2), 32'd7);

        // Preload every word, then random traffic against the model
        for (int i = 0; i < 256; i++)
            acc_model($sformatf("pre%0d", i), 1'b1, 32'(i * 4), $urandom, 4'hF);
        for (int i = 0; i < 300; i++) begin
            rk = 4'($urandom_range(0, 9));
            if (rk == 4'd0)      ra = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
            else if (rk == 4'd1) ra = $urandom | 32'h0000_0400;
            else                 ra = 32'($urandom_range(0, 255)) << 2;
            acc_model($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), ra, $urandom,
                      4'($urandom_range(0, 15)));
        end

        // Reset abort on the LATENCY=4 instance
        cur = 1'b1;
        access("b_pre",  1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
        access("b_load", 1'b0, 32'h20, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF;
        @(negedge clk);
        check("abort/ack_w1", 32'(o_ack), 32'd0);
        @(negedge clk);
        b_rst_n = 1'b0;
        req = 1'b0;
        #1;
        check("abort/ready_rst", 32'(o_ready), 32'd1);
        check("abort/rdata_rst", o_rdata, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("abort/ack_rst%0d", c), 32'(o_ack), 32'd0);
        end
        b_rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("abort/ack_post%0d", c), 32'(o_ack), 32'd0);
            check($sformatf("abort/ready_post%0d", c), 32'(o_ready), 32'd1);
        end
        access("b_after", 1'b0, 32'h20, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
